exe_mem_pipe_reg: RTL and testbench
===================================

# exe_mem_pipe_reg

Parametrised, elastic EXE→MEM pipeline register for the ARM pipeline. It carries the memory-control flags, write-back enable, destination register, store data (Rm) and ALU result, with a valid/ready handshake on both sides. An optional 2-entry skid buffer lets the EXE stage keep issuing while MEM stalls. It supports flush (bubble insertion) and exports the destination and write-back enable of the youngest held instruction to the forwarding unit.

## Interface
Parameters:
- DATA_W, 32, width of ALU result and Rm store data
- REG_W, 4, width of the destination register index
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready

Ports:
- clk  in  1  rising-edge clock; one clock domain
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  EXE presents a beat
- in_ready  out  1  stage can accept a beat
- flush  in  1  kill every held and incoming beat
- mem_r_en_in, mem_w_en_in, wb_en_in  in  1 each  control flags
- reg_dest_in  in  REG_W  destination register
- rm_in, alu_result_in  in  DATA_W  store data, address/result
- out_valid  out  1  beat presented to MEM
- out_ready  in  1  MEM accepts the beat
- mem_read, mem_write, wb_en  out  1 each  flags, forced 0 when out_valid=0
- reg_dest_out  out  REG_W  destination register
- rm_out, alu_result  out  DATA_W  data fields
- fwd_wb_en  out  1  wb_en of the youngest valid held entry; 0 if none
- fwd_dest  out  REG_W  reg_dest of that entry

## Operation
- Accept: in_valid && in_ready. Release: out_valid && out_ready.
- Storage: main entry (drives outputs) and, when SKID=1, a skid entry. Each entry holds a valid bit plus all fields.
- States when SKID=1:
  - EMPTY → ONE on accept.
  - ONE stays ONE on accept+release (main reloads) or on idle.
  - ONE → EMPTY on release without accept.
  - ONE → TWO on accept without release (the beat goes to skid).
  - TWO → ONE on release: skid moves to main.
- In TWO, in_ready=0, so accept is impossible.
- in_ready when SKID=1 = (state != TWO), taken from a register.
- SKID=0: states EMPTY/ONE only. in_ready = !out_valid || out_ready (combinational path from out_ready).
- Flush: the next state is EMPTY. All valid bits clear. A beat accepted in the flush cycle is discarded. The release that cycle still counts as done. Data fields may hold stale values.
- Flush has priority over every other event. reset has priority over flush.
- Control masking: mem_read, mem_write and wb_en = stored flag AND out_valid. Data fields are not masked.
- Forwarding: the youngest entry is skid if valid, else main. Its fwd_wb_en and fwd_dest are combinational from the registers. fwd_wb_en=0 while flush is asserted.
- No arithmetic; all fields pass through width-exact.

## Timing
- Latency: a beat accepted at edge N appears on the outputs after edge N, in the cycle that ends with edge N+1.
- Full throughput: 1 beat/cycle with out_ready held high.
- Back-pressure:
  - SKID=1: in_ready falls one cycle after the stall begins. Up to one extra beat is absorbed.
  - SKID=0: in_ready reflects the stall in the same cycle.
- Order is preserved; no beat is duplicated or dropped except by flush.
- Reset (synchronous) values: state EMPTY, all valid bits 0, all flags 0, reg_dest_out 0, rm_out 0, alu_result 0, fwd_wb_en 0, fwd_dest 0.
- in_ready after reset: 1 for both SKID settings.
- Reset mid-stall discards all held entries, as flush does.
- out_valid/data must stay stable while out_valid && !out_ready (no flush).

## Structure
- Shared pipeline package:
  - typedef exe_mem_t {mem_r_en, mem_w_en, wb_en, reg_dest, rm, alu_result}, parametrised via DATA_W/REG_W constants.
  - state encoding constants EMPTY/ONE/TWO.
- A natural sub-module is pipe_entry: a valid flag plus an exe_mem_t register with load/clear controls, instantiated twice.
- The top holds the state machine, muxing, masking and forwarding outputs.

## Test plan
- Reset, then stream: hold out_ready=1, send alu_result 0x10, 0x20, 0x30 on consecutive cycles → each appears one cycle later. out_valid stays continuous and in_ready stays 1.
- Stall absorb (SKID=1):
  - Set out_ready=0 while sending 0xA, then 0xB → state TWO, in_ready=0, outputs show 0xA.
  - Raise out_ready → 0xA, then 0xB, released in order.
- Flush in TWO: hold 0xA/0xB, assert flush with in_valid carrying 0xC → next cycle out_valid=0, mem_read=mem_write=wb_en=0, fwd_wb_en=0, and 0xC is never emitted.
- Forwarding:
  - Main holds wb_en=1, dest=3; skid takes wb_en=1, dest=7 → fwd_dest=7.
  - After release → fwd_dest=7 from main.
  - Empty → fwd_wb_en=0.
- SKID=0 stall: send a beat with mem_w_en=1, rm=0xDEAD and out_ready=0 → in_ready=0 in the same cycle, and outputs hold rm_out=0xDEAD with mem_write=1 until release.
- Reset mid-operation: assert reset in TWO → next cycle every output is 0 and in_ready=1.

Source files
------------

// File: rtl/exe_mem_pipe_reg_pkg.sv
// Shared EXE->MEM pipeline types: beat layout at the default widths and the
// occupancy encoding used by the elastic stage register.
package exe_mem_pipe_reg_pkg;

    localparam int EM_DATA_W = 32;
    localparam int EM_REG_W  = 4;

    // Beat carried from EXE to MEM at the default core widths
    typedef struct packed {
        logic                 mem_r_en;
        logic                 mem_w_en;
        logic                 wb_en;
        logic [EM_REG_W-1:0]  reg_dest;
        logic [EM_DATA_W-1:0] rm;
        logic [EM_DATA_W-1:0] alu_result;
    } exe_mem_t;

    // Number of held beats
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

endpackage

// File: rtl/exe_mem_pipe_reg_pipe_entry.sv
// One storage slot of the EXE->MEM register: valid flag plus a beat payload.
// Clear only drops the valid bit; the payload keeps its last value.
module exe_mem_pipe_reg_pipe_entry #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_clear,
    input  T     i_d,
    output logic o_valid,
    output T     o_q
);

    // Clear wins over load so a flush can never leave a live beat behind
    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_q     <= '0;
        end else if (i_clear) begin
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_q     <= i_d;
        end
    end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// Elastic EXE->MEM pipeline register with optional two-entry skid buffer,
// flush, output flag masking and forwarding of the youngest held destination.
module exe_mem_pipe_reg
    import exe_mem_pipe_reg_pkg::*;
#(
    parameter int DATA_W = EM_DATA_W,
    parameter int REG_W  = EM_REG_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              wb_en_in,
    input  logic [REG_W-1:0]  reg_dest_in,
    input  logic [DATA_W-1:0] rm_in,
    input  logic [DATA_W-1:0] alu_result_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_en,
    output logic [REG_W-1:0]  reg_dest_out,
    output logic [DATA_W-1:0] rm_out,
    output logic [DATA_W-1:0] alu_result,
    output logic              fwd_wb_en,
    output logic [REG_W-1:0]  fwd_dest
);

    // Same layout as exe_mem_t, sized by this instance's parameters
    typedef struct packed {
        logic              mem_r_en;
        logic              mem_w_en;
        logic              wb_en;
        logic [REG_W-1:0]  reg_dest;
        logic [DATA_W-1:0] rm;
        logic [DATA_W-1:0] alu_result;
    } entry_t;

    occ_state_e r_state;
    occ_state_e w_state_nxt;
    entry_t     w_in_beat;
    entry_t     w_main_d;
    entry_t     w_main_q;
    entry_t     w_skid_q;
    logic       w_main_vld;
    logic       w_skid_vld;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_release;
    logic       w_main_load;
    logic       w_main_from_skid;
    logic       w_main_clr;
    logic       w_skid_load;
    logic       w_skid_clr;

    assign w_in_beat = '{mem_r_en:   mem_r_en_in,
                         mem_w_en:   mem_w_en_in,
                         wb_en:      wb_en_in,
                         reg_dest:   reg_dest_in,
                         rm:         rm_in,
                         alu_result: alu_result_in};

    assign w_accept  = in_valid && w_in_ready;
    assign w_release = w_main_vld && out_ready;

    // Occupancy transitions; flush empties everything and drops any incoming beat
    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_main_clr       = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clr       = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_clr  = 1'b1;
            w_skid_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_main_load = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_release) begin
                        w_main_load = 1'b1;
                    end else if (w_accept && (SKID != 0)) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = ST_TWO;
                    end else if (w_release) begin
                        w_main_clr  = 1'b1;
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_release) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clr       = 1'b1;
                        w_state_nxt      = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_clr  = 1'b1;
                    w_skid_clr  = 1'b1;
                end
            endcase
        end
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_EMPTY;
        else       r_state <= w_state_nxt;
    end

    // Main entry reloads from skid when draining TWO, otherwise from EXE
    assign w_main_d = w_main_from_skid ? w_skid_q : w_in_beat;

    exe_mem_pipe_reg_pipe_entry #(.T(entry_t)) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_main_load),
        .i_clear (w_main_clr),
        .i_d     (w_main_d),
        .o_valid (w_main_vld),
        .o_q     (w_main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic r_in_ready;

            // in_ready comes from a flop: low exactly while both entries are full
            always_ff @(posedge clk) begin
                if (reset) r_in_ready <= 1'b1;
                else       r_in_ready <= (w_state_nxt != ST_TWO);
            end

            assign w_in_ready = r_in_ready;

            exe_mem_pipe_reg_pipe_entry #(.T(entry_t)) u_skid (
                .clk     (clk),
                .reset   (reset),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clr),
                .i_d     (w_in_beat),
                .o_valid (w_skid_vld),
                .o_q     (w_skid_q)
            );
        end else begin : g_noskid
            // Single entry: can take a beat whenever the current one leaves
            assign w_in_ready = !w_main_vld || out_ready;
            assign w_skid_vld = 1'b0;
            assign w_skid_q   = '0;
        end
    endgenerate

    assign in_ready     = w_in_ready;
    assign out_valid    = w_main_vld;
    assign mem_read     = w_main_q.mem_r_en && w_main_vld;
    assign mem_write    = w_main_q.mem_w_en && w_main_vld;
    assign wb_en        = w_main_q.wb_en    && w_main_vld;
    assign reg_dest_out = w_main_q.reg_dest;
    assign rm_out       = w_main_q.rm;
    assign alu_result   = w_main_q.alu_result;

    // Youngest held instruction is the skid entry when present
    assign fwd_wb_en = !flush && (w_skid_vld ? w_skid_q.wb_en : (w_main_vld && w_main_q.wb_en));
    assign fwd_dest  = w_skid_vld ? w_skid_q.reg_dest : w_main_q.reg_dest;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Bench for exe_mem_pipe_reg: SKID=1 and SKID=0 instances share stimulus and
// are checked against a queue model plus directed table/sequence expectations.
module tb_exe_mem_pipe_reg;

    logic        clk;
    logic        reset, in_valid, flush, out_ready;
    logic        mr_in, mw_in, wb_in;
    logic [3:0]  dest_in;
    logic [31:0] rm_in, alu_in;

    logic        ir1, ov1, mr1, mw1, wb1, fe1;
    logic [3:0]  d1, fd1;
    logic [31:0] rm1, a1;
    logic        ir0, ov0, mr0, mw0, wb0, fe0;
    logic [3:0]  d0, fd0;
    logic [31:0] rm0, a0;

    int n_tests, n_fail;

    typedef struct packed {
        logic        mr, mw, wb;
        logic [3:0]  dest;
        logic [31:0] rm, alu;
    } beat_t;

    beat_t q1[$];
    beat_t q0[$];

    typedef struct {
        logic v, r, f, wb;
        logic [3:0]  d;
        logic [31:0] a;
        logic        e_ov;
        logic [31:0] e_a;
        logic        e_ir, e_fe;
        logic [3:0]  e_fd;
    } vec_t;

    localparam int NROWS = 19;
    vec_t tbl[NROWS];

    exe_mem_pipe_reg #(.DATA_W(32), .REG_W(4), .SKID(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .flush(flush),
        .mem_r_en_in(mr_in), .mem_w_en_in(mw_in), .wb_en_in(wb_in), .reg_dest_in(dest_in),
        .rm_in(rm_in), .alu_result_in(alu_in), .out_valid(ov1), .out_ready(out_ready),
        .mem_read(mr1), .mem_write(mw1), .wb_en(wb1), .reg_dest_out(d1), .rm_out(rm1),
        .alu_result(a1), .fwd_wb_en(fe1), .fwd_dest(fd1)
    );

    exe_mem_pipe_reg #(.DATA_W(32), .REG_W(4), .SKID(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0), .flush(flush),
        .mem_r_en_in(mr_in), .mem_w_en_in(mw_in), .wb_en_in(wb_in), .reg_dest_in(dest_in),
        .rm_in(rm_in), .alu_result_in(alu_in), .out_valid(ov0), .out_ready(out_ready),
        .mem_read(mr0), .mem_write(mw0), .wb_en(wb0), .reg_dest_out(d0), .rm_out(rm0),
        .alu_result(a0), .fwd_wb_en(fe0), .fwd_dest(fd0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, r, f, mr, mw, wb, input logic [3:0] d,
                         input logic [31:0] rmv, a);
        in_valid  = v;
        out_ready = r;
        flush     = f;
        mr_in     = mr;
        mw_in     = mw;
        wb_in     = wb;
        dest_in   = d;
        rm_in     = rmv;
        alu_in    = a;
    endtask

    // Compare one DUT against the queue model (head = oldest, tail = youngest)
    task automatic chk_dut(input string tag, input int skid, input logic ir, ov, mr, mw, wb,
                           input logic [3:0] d, input logic [31:0] rmv, a,
                           input logic fe, input logic [3:0] fd);
        beat_t q[$];
        int    n;
        logic  e_ir;
        if (skid != 0) q = q1;
        else           q = q0;
        n    = q.size();
        e_ir = (skid != 0) ? (n < 2) : ((n == 0) || out_ready);
        chk1({tag, ".in_ready"}, ir, e_ir);
        chk1({tag, ".out_valid"}, ov, n > 0);
        if (n > 0) begin
            chk1({tag, ".mem_read"}, mr, q[0].mr);
            chk1({tag, ".mem_write"}, mw, q[0].mw);
            chk1({tag, ".wb_en"}, wb, q[0].wb);
            chkw({tag, ".reg_dest"}, {28'd0, d}, {28'd0, q[0].dest});
            chkw({tag, ".rm_out"}, rmv, q[0].rm);
            chkw({tag, ".alu_result"}, a, q[0].alu);
            chkw({tag, ".fwd_dest"}, {28'd0, fd}, {28'd0, q[n-1].dest});
        end else begin
            chk1({tag, ".mem_read"}, mr, 1'b0);
            chk1({tag, ".mem_write"}, mw, 1'b0);
            chk1({tag, ".wb_en"}, wb, 1'b0);
        end
        chk1({tag, ".fwd_wb_en"}, fe, (n > 0) && !flush && q[n-1].wb);
    endtask

    // Model update at the clock edge from the inputs held during the cycle
    task automatic model_upd();
        beat_t b;
        bit    acc1, rel1, acc0, rel0;
        b.mr   = mr_in;
        b.mw   = mw_in;
        b.wb   = wb_in;
        b.dest = dest_in;
        b.rm   = rm_in;
        b.alu  = alu_in;
        acc1 = in_valid && (q1.size() < 2);
        rel1 = (q1.size() > 0) && out_ready;
        acc0 = in_valid && ((q0.size() == 0) || out_ready);
        rel0 = (q0.size() > 0) && out_ready;
        if (reset || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (rel1) void'(q1.pop_front());
            if (acc1) q1.push_back(b);
            if (rel0) void'(q0.pop_front());
            if (acc0) q0.push_back(b);
        end
    endtask

    task automatic cycle_end();
        chk_dut("s1", 1, ir1, ov1, mr1, mw1, wb1, d1, rm1, a1, fe1, fd1);
        chk_dut("s0", 0, ir0, ov0, mr0, mw0, wb0, d0, rm0, a0, fe0, fd0);
        @(posedge clk);
        model_upd();
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, ".s1.in_ready"}, ir1, 1'b1);
        chk1({tag, ".s1.out_valid"}, ov1, 1'b0);
        chkw({tag, ".s1.flags"}, {29'd0, mr1, mw1, wb1}, 32'd0);
        chkw({tag, ".s1.reg_dest"}, {28'd0, d1}, 32'd0);
        chkw({tag, ".s1.rm_out"}, rm1, 32'd0);
        chkw({tag, ".s1.alu_result"}, a1, 32'd0);
        chk1({tag, ".s1.fwd_wb_en"}, fe1, 1'b0);
        chkw({tag, ".s1.fwd_dest"}, {28'd0, fd1}, 32'd0);
        chk1({tag, ".s0.in_ready"}, ir0, 1'b1);
        chk1({tag, ".s0.out_valid"}, ov0, 1'b0);
        chkw({tag, ".s0.flags"}, {29'd0, mr0, mw0, wb0}, 32'd0);
        chkw({tag, ".s0.rm_out"}, rm0, 32'd0);
        chkw({tag, ".s0.alu_result"}, a0, 32'd0);
        chk1({tag, ".s0.fwd_wb_en"}, fe0, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        //            v     r     f     wb    d      a        e_ov  e_a      e_ir  e_fe  e_fd
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h10, 1'b0, 32'h0,  1'b1, 1'b0, 4'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h20, 1'b1, 32'h10, 1'b1, 1'b0, 4'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h30, 1'b1, 32'h20, 1'b1, 1'b0, 4'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,  1'b1, 32'h30, 1'b1, 1'b0, 4'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 4'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 32'hA,  1'b0, 32'h0,  1'b1, 1'b0, 4'd0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 32'hB,  1'b1, 32'hA,  1'b1, 1'b1, 4'd3};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,  1'b1, 32'hA,  1'b0, 1'b1, 4'd7};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,  1'b1, 32'hA,  1'b0, 1'b1, 4'd7};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,  1'b1, 32'hB,  1'b1, 1'b1, 4'd7};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 4'd0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 32'hA,  1'b0, 32'h0,  1'b1, 1'b0, 4'd0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 32'hB,  1'b1, 32'hA,  1'b1, 1'b1, 4'd3};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 32'hC,  1'b1, 32'hA,  1'b0, 1'b0, 4'd0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 4'd0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 4'd0};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h55, 1'b0, 32'h0,  1'b1, 1'b0, 4'd0};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 32'h66, 1'b1, 32'h55, 1'b1, 1'b0, 4'd0};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 4'd0};

        // Reset state
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // Directed table: stream, stall absorb, forwarding, flush in TWO and ONE
        for (int i = 0; i < NROWS; i++) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].f, 1'b0, 1'b0, tbl[i].wb, tbl[i].d,
                  ~tbl[i].a, tbl[i].a);
            #1;
            chk1($sformatf("tbl%0d.out_valid", i), ov1, tbl[i].e_ov);
            if (tbl[i].e_ov) chkw($sformatf("tbl%0d.alu_result", i), a1, tbl[i].e_a);
            chk1($sformatf("tbl%0d.in_ready", i), ir1, tbl[i].e_ir);
            chk1($sformatf("tbl%0d.fwd_wb_en", i), fe1, tbl[i].e_fe);
            if (tbl[i].e_fe) chkw($sformatf("tbl%0d.fwd_dest", i), {28'd0, fd1}, {28'd0, tbl[i].e_fd});
            cycle_end();
        end

        // Single-entry stall: in_ready follows out_ready in the same cycle
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 32'hDEAD, 32'h100);
        #1;
        chk1("s0stall.a.in_ready", ir0, 1'b1);
        cycle_end();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 32'h1111, 32'h200);
        #1;
        chk1("s0stall.b.in_ready", ir0, 1'b0);
        chkw("s0stall.b.rm_out", rm0, 32'hDEAD);
        chk1("s0stall.b.mem_write", mw0, 1'b1);
        cycle_end();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
        #1;
        chkw("s0stall.c.rm_out", rm0, 32'hDEAD);
        chk1("s0stall.c.mem_write", mw0, 1'b1);
        cycle_end();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
        #1;
        chk1("s0stall.d.in_ready", ir0, 1'b1);
        chkw("s0stall.d.rm_out", rm0, 32'hDEAD);
        cycle_end();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
        #1;
        chk1("s0stall.e.out_valid", ov0, 1'b0);
        chk1("s0stall.e.mem_write", mw0, 1'b0);
        cycle_end();

        // Reset while the skid instance is full
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd8, 32'h3333, 32'h300);
        #1;
        cycle_end();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
        #1;
        chk1("rsttwo.pre.in_ready", ir1, 1'b0);
        reset = 1'b1;
        cycle_end();
        reset = 1'b0;
        #1;
        chk_zero("rsttwo");
        cycle_end();

        // Randomized traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(63) == 0);
            drive($urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(15) == 0,
                  1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom);
            #1;
            cycle_end();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
